// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Progressive raster timing generator feeding the DVI TMDS encoders.
//   Produces DE / HSYNC / VSYNC plus the pixel coordinates they describe.
//   Defaults give 640x480@60 (25.175 MHz pixel clock).
//
//   Optional feature: define VIDEO_TIMING_PATTERN_EN to add the rgb_o port,
//   an 8-bar colour test pattern aligned with de_o. Without the macro the
//   port and all pattern logic are absent and timing is identical.
//
// Ports
//   clk_i          pixel clock
//   rst_i          asynchronous active-high reset
//   en_i           pixel-clock enable; low freezes all state and outputs
//   de_o           data enable, high inside the active area
//   hsync_o        horizontal sync, active level H_SYNC_POL
//   vsync_o        vertical sync, active level V_SYNC_POL
//   x_o, y_o       position described by the other outputs this cycle
//   line_start_o   high while x_o == 0
//   frame_start_o  high while x_o == 0 and y_o == 0
//   rgb_o          {R,G,B} test pattern (VIDEO_TIMING_PATTERN_EN only)
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int W_H       = $clog2(H_TOTAL),
  localparam int W_V       = $clog2(V_TOTAL)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  output logic           de_o,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic [W_H-1:0] x_o,
  output logic [W_V-1:0] y_o,
  output logic           line_start_o,
`ifdef VIDEO_TIMING_PATTERN_EN
  output logic           frame_start_o,
  output logic [23:0]    rgb_o
`else
  output logic           frame_start_o
`endif
);

  // Inclusive bounds, so no constant ever needs to hold H_TOTAL / V_TOTAL.
  localparam logic [W_H-1:0] H_LAST     = W_H'(H_TOTAL - 1);
  localparam logic [W_H-1:0] H_ACT_LAST = W_H'(H_ACTIVE - 1);
  localparam logic [W_H-1:0] HS_FIRST   = W_H'(H_ACTIVE + H_FP);
  localparam logic [W_H-1:0] HS_LAST    = W_H'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [W_V-1:0] V_LAST     = W_V'(V_TOTAL - 1);
  localparam logic [W_V-1:0] V_ACT_LAST = W_V'(V_ACTIVE - 1);
  localparam logic [W_V-1:0] VS_FIRST   = W_V'(V_ACTIVE + V_FP);
  localparam logic [W_V-1:0] VS_LAST    = W_V'(V_ACTIVE + V_FP + V_SYNC - 1);

  // The counters hold the position that the *next* enabled edge presents;
  // every output register is decoded from them, so all outputs stay aligned.
  logic [W_H-1:0] h_cnt;
  logic [W_V-1:0] v_cnt;
  logic [W_H-1:0] h_next;
  logic [W_V-1:0] v_next;
  logic           h_wrap;
  logic           de_next;
  logic           hs_active;
  logic           vs_active;

  always_comb begin
    h_wrap    = (h_cnt == H_LAST);
    h_next    = h_wrap ? '0 : h_cnt + 1'b1;
    v_next    = v_cnt;
    if (h_wrap) begin
      v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
    de_next   = (h_cnt <= H_ACT_LAST) && (v_cnt <= V_ACT_LAST);
    hs_active = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    // Decoded from v_cnt alone, so vsync edges land on x == 0.
    vs_active = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  end

`ifdef VIDEO_TIMING_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  // Thermometer code: past_edge[gi] is set once x reaches bar gi+1.
  logic [6:0]  past_edge;
  logic [2:0]  bar;
  logic [23:0] rgb_next;

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_bar_edge
      localparam logic [W_H-1:0] EDGE = W_H'(BAR_W * (gi + 1));
      assign past_edge[gi] = (h_cnt >= EDGE);
    end
  endgenerate

  always_comb begin
    bar = '0;
    for (int i = 0; i < 7; i++) begin
      if (past_edge[i]) bar = 3'(i + 1);
    end
    case (bar)
      3'd0:    rgb_next = 24'hFFFFFF;
      3'd1:    rgb_next = 24'hFFFF00;
      3'd2:    rgb_next = 24'h00FFFF;
      3'd3:    rgb_next = 24'h00FF00;
      3'd4:    rgb_next = 24'hFF00FF;
      3'd5:    rgb_next = 24'hFF0000;
      3'd6:    rgb_next = 24'h0000FF;
      default: rgb_next = 24'h000000;
    endcase
    if (!de_next) rgb_next = 24'h000000;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      de_o          <= 1'b0;
      hsync_o       <= ~H_SYNC_POL;
      vsync_o       <= ~V_SYNC_POL;
      x_o           <= '0;
      y_o           <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
`ifdef VIDEO_TIMING_PATTERN_EN
      rgb_o         <= '0;
`endif
    end else if (en_i) begin
      h_cnt         <= h_next;
      v_cnt         <= v_next;
      de_o          <= de_next;
      hsync_o       <= hs_active ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_o       <= vs_active ? V_SYNC_POL : ~V_SYNC_POL;
      x_o           <= h_cnt;
      y_o           <= v_cnt;
      line_start_o  <= (h_cnt == '0);
      frame_start_o <= (h_cnt == '0) && (v_cnt == '0);
`ifdef VIDEO_TIMING_PATTERN_EN
      rgb_o         <= rgb_next;
`endif
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen using a reduced raster
// (16+2+3+3 = 24 px per line, 4+1+2+1 = 8 lines per frame, vsync active-high)
// so several frames fit in a short run.
`timescale 1ns/1ps
module tb_video_timing_gen;
  localparam int HT = 24;    // 16 + 2 + 3 + 3
  localparam int VT = 8;     // 4 + 1 + 2 + 1
  localparam int FRAME = 192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       de, hsync, vsync, ls, fs;
  logic [4:0] x;
  logic [2:0] y;
`ifdef VIDEO_TIMING_PATTERN_EN
  logic [23:0] rgb;
`endif

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .de_o(de), .hsync_o(hsync), .vsync_o(vsync),
    .x_o(x), .y_o(y),
    .line_start_o(ls),
`ifdef VIDEO_TIMING_PATTERN_EN
    .frame_start_o(fs),
    .rgb_o(rgb)
`else
    .frame_start_o(fs)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  x;
    logic [2:0]  y;
    logic        de, hs, vs, ls, fs;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   mx, my;
  int   errors = 0;
  int   checks = 0;

  // monitor statistics
  int   cyc = 0;
  int   fs_last = -1, fs_period = 0;
  int   ls_last = -1, ls_period = 0;
  int   vs_cnt = 0, hs0_cnt = 0;
  logic prev_fs = 1'b0, prev_ls = 1'b0;

  function automatic logic [23:0] bar_colour(input int b);
    case (b)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected outputs for a raster position, from hand-derived boundaries:
  // active x 0..15 / y 0..3, hsync low x 18..20, vsync high y 5..6.
  function automatic exp_t decode(input int px, input int py);
    exp_t e;
    e     = '0;
    e.x   = 5'(px);
    e.y   = 3'(py);
    e.de  = (px < 16) && (py < 4);
    e.hs  = (px >= 18 && px <= 20) ? 1'b0 : 1'b1;
    e.vs  = (py >= 5 && py <= 6) ? 1'b1 : 1'b0;
    e.ls  = (px == 0);
    e.fs  = (px == 0) && (py == 0);
`ifdef VIDEO_TIMING_PATTERN_EN
    e.rgb = e.de ? bar_colour(px / 2) : 24'h000000;
`endif
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b0;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a    = '0;
    a.x  = x;  a.y = y;
    a.de = de; a.hs = hsync; a.vs = vsync; a.ls = ls; a.fs = fs;
`ifdef VIDEO_TIMING_PATTERN_EN
    a.rgb = rgb;
`endif
    return a;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b rgb=%h",
                     e.x, e.y, e.de, e.hs, e.vs, e.ls, e.fs, e.rgb);
  endfunction

  task automatic check_state(input string name, input exp_t want);
    exp_t a;
    a = actual();
    checks++;
    if (a !== want) begin
      errors++;
      $display("FAIL %s: got %s want %s", name, fmt(a), fmt(want));
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // One clock of stimulus; the expected response goes to the scoreboard.
  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    #1;
    if (e) begin
      cur = decode(mx, my);
      mx++;
      if (mx == HT) begin
        mx = 0;
        my++;
        if (my == VT) my = 0;
      end
    end
    q.push_back(cur);
  endtask

  // Monitor: pops one expectation per sampled cycle and compares.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      a = actual();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scan cyc=%0d: got %s want %s", cyc, fmt(a), fmt(e));
      end
      if (fs && !prev_fs) begin
        if (fs_last >= 0) fs_period = cyc - fs_last;
        fs_last = cyc;
      end
      if (ls && !prev_ls) begin
        if (ls_last >= 0) ls_period = cyc - ls_last;
        ls_last = cyc;
      end
      if (vsync) vs_cnt++;
      if (y == 3'd0 && !hsync) hs0_cnt++;
      prev_fs = fs;
      prev_ls = ls;
      cyc++;
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t h;
    int   vs0, hs0;
    bit   reached;

    cur = reset_exp();
    mx  = 0;
    my  = 0;

    // Reset held with en high: outputs must stay at reset values.
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_state("reset_hold", reset_exp());
    rst = 1'b0;

    // Phase A: continuous enable, two frames and a bit.
    vs0 = vs_cnt;
    hs0 = hs0_cnt;
    step(1'b1);
    @(negedge clk);
    #1;
    h = '0;
    h.de = 1'b1; h.hs = 1'b1; h.ls = 1'b1; h.fs = 1'b1;
`ifdef VIDEO_TIMING_PATTERN_EN
    h.rgb = 24'hFFFFFF;
`endif
    check_state("first_edge", h);
    repeat (2 * FRAME + 4) step(1'b1);
    @(negedge clk);
    #1;
    check_int("frame_period", fs_period, 192);
    check_int("line_period", ls_period, 24);
    check_int("vsync_cycles_2frames", vs_cnt - vs0, 96);
    check_int("hsync_cycles_line0_2frames", hs0_cnt - hs0, 6);

    // Phase B: enable alternating, periods double.
    for (int i = 0; i < 800; i++) step((i % 2) == 0);
    @(negedge clk);
    #1;
    check_int("frame_period_half_en", fs_period, 384);
    check_int("line_period_half_en", ls_period, 48);

    // Phase C: asynchronous reset while showing (x=10, y=2).
    reached = 1'b0;
    for (int i = 0; i < 500 && !reached; i++) begin
      step(1'b1);
      reached = (cur.x == 5'd10) && (cur.y == 3'd2);
    end
    if (!reached) begin
      checks++;
      errors++;
      $display("FAIL reach_pos: got not reached want x=10 y=2");
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_state("async_reset", reset_exp());
    q.delete();
    cur = reset_exp();
    mx  = 0;
    my  = 0;
    en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_state("reset_hold_en", reset_exp());
    rst = 1'b0;
    step(1'b1);
    @(negedge clk);
    #1;
    check_state("restart_origin", h);
    repeat (2 * HT) step(1'b1);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
